// File: rtl/led_fault_class_scheduler_if.sv
// Signal bundle between the fault aggregation side and the health-LED blink-code sequencer.
// fault_vld is a level/pulse request with no ready: the sequencer OR-latches it every cycle.
interface led_fault_class_scheduler_if #(
    parameter int NUM_CLASSES = 11,
    parameter int CLS_W       = 4
);
    logic                   blink_tick;
    logic [NUM_CLASSES-1:0] fault_vld;
    logic                   fault_clr;
    logic                   blink_en;
    logic                   health_led;
    logic [CLS_W-1:0]       active_class;
    logic [NUM_CLASSES-1:0] class_latched;
    logic                   seq_busy;
    logic                   seq_done;
    logic [1:0]             fsm_state;

    modport master (
        output blink_tick, fault_vld, fault_clr, blink_en,
        input  health_led, active_class, class_latched, seq_busy, seq_done, fsm_state
    );

    modport slave (
        input  blink_tick, fault_vld, fault_clr, blink_en,
        output health_led, active_class, class_latched, seq_busy, seq_done, fsm_state
    );
endinterface

// File: rtl/led_fault_class_scheduler.sv
// Health-LED blink-code sequencer: latches fault classes and shows each latched class k as
// an LED-off gap followed by k+1 blinks, serving latched classes in round-robin order.
module led_fault_class_scheduler #(
    parameter int NUM_CLASSES = 11,
    parameter int GAP_TICKS   = 8,
    parameter int CLS_W       = 4
) (
    input  logic                         sys_clk,
    input  logic                         reset_n,
    led_fault_class_scheduler_if.slave   bus
);
    localparam int BW = $clog2(NUM_CLASSES + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GAP       = 2'd1;
    localparam logic [1:0] BLINK_ON  = 2'd2;
    localparam logic [1:0] BLINK_OFF = 2'd3;

    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_TICKS - 1);
    localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASSES - 1);
    localparam logic [CLS_W:0]   NC       = (CLS_W + 1)'(NUM_CLASSES);

    logic [1:0]             state, state_n;
    logic [GW-1:0]          gap_cnt, gap_n;
    logic [BW-1:0]          blink_cnt, blink_n;
    logic [CLS_W-1:0]       active_class, active_n;
    logic [CLS_W-1:0]       search_start, start_n;
    logic [NUM_CLASSES-1:0] latched;
    logic                   led, busy, done, done_n;

    logic [NUM_CLASSES-1:0] rot;
    logic                   pick_found;
    logic [CLS_W-1:0]       pick_idx;
    logic [CLS_W:0]         pick_sum;
    logic                   abort;
    logic                   blink_last;

    // Rotate the latches so bit 0 is the class right after the last one served.
    assign rot = NUM_CLASSES'({latched, latched} >> search_start);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (!pick_found && rot[i]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, search_start} + (CLS_W + 1)'(i);
                if (pick_sum >= NC) begin
                    pick_sum = pick_sum - NC;
                end
                pick_idx = pick_sum[CLS_W-1:0];
            end
        end
    end

    assign abort      = bus.fault_clr | ~bus.blink_en;
    assign blink_last = ((CLS_W + BW)'(blink_cnt) == (CLS_W + BW)'(active_class));

    always_comb begin
        state_n  = state;
        gap_n    = gap_cnt;
        blink_n  = blink_cnt;
        active_n = active_class;
        start_n  = search_start;
        done_n   = 1'b0;
        if (state == IDLE) begin
            if (bus.blink_en && (|latched)) begin
                state_n  = GAP;
                active_n = pick_idx;
                gap_n    = '0;
                blink_n  = '0;
            end
        end else if (abort) begin
            // Abort wins over a same-cycle tick and leaves the round-robin pointer alone.
            state_n = IDLE;
        end else if (bus.blink_tick) begin
            case (state)
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n = BLINK_ON;
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
                end
                BLINK_ON: begin
                    state_n = BLINK_OFF;
                end
                BLINK_OFF: begin
                    if (blink_last) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        start_n = (active_class == CLS_LAST) ? '0 : active_class + 1'b1;
                    end else begin
                        blink_n = blink_cnt + 1'b1;
                        state_n = BLINK_ON;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            blink_cnt    <= '0;
            active_class <= '0;
            search_start <= '0;
            latched      <= '0;
            led          <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            gap_cnt      <= gap_n;
            blink_cnt    <= blink_n;
            active_class <= active_n;
            search_start <= start_n;
            // A set arriving with the clear survives it.
            latched      <= bus.fault_clr ? bus.fault_vld : (latched | bus.fault_vld);
            led          <= (state_n != BLINK_ON);
            busy         <= (state_n != IDLE);
            done         <= done_n;
        end
    end

    assign bus.health_led    = led;
    assign bus.active_class  = active_class;
    assign bus.class_latched = latched;
    assign bus.seq_busy      = busy;
    assign bus.seq_done      = done;
    assign bus.fsm_state     = state;

endmodule

// File: tb/tb_led_fault_class_scheduler.sv
// Bench for the blink-code sequencer: burst-level reference model, per-cycle output checks and
// an expected-burst queue popped whenever the sequencer reports a completed burst.
module tb_led_fault_class_scheduler;
  localparam int N     = 11;
  localparam int GAP   = 2;
  localparam int CLS_W = 4;
  localparam int W     = 12;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;

  led_fault_class_scheduler_if #(.NUM_CLASSES(N), .CLS_W(CLS_W)) bus ();

  led_fault_class_scheduler #(.NUM_CLASSES(N), .GAP_TICKS(GAP), .CLS_W(CLS_W)) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (burst level, tick counting) ----------------
  logic [N-1:0] m_latched = '0;
  logic [N-1:0] m_old;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_cls = 0;
  int m_ticks = 0;
  int m_start = 0;
  int m_pick;

  always @(posedge sys_clk) begin
    m_done = 1'b0;
    if (!reset_n) begin
      m_latched = '0;
      m_busy    = 1'b0;
      m_cls     = 0;
      m_ticks   = 0;
      m_start   = 0;
    end else begin
      m_old     = m_latched;
      m_latched = bus.fault_clr ? bus.fault_vld : (m_latched | bus.fault_vld);
      if (!m_busy) begin
        if (bus.blink_en && m_old != '0) begin
          m_pick = -1;
          for (int i = 0; i < N; i++)
            if (m_pick < 0 && m_old[(m_start + i) % N]) m_pick = (m_start + i) % N;
          m_cls   = m_pick;
          m_busy  = 1'b1;
          m_ticks = 0;
        end
      end else if (bus.fault_clr || !bus.blink_en) begin
        m_busy = 1'b0;
      end else if (bus.blink_tick) begin
        m_ticks++;
        if (m_ticks == GAP + 2 * (m_cls + 1)) begin
          m_busy  = 1'b0;
          m_done  = 1'b1;
          m_start = (m_cls + 1) % N;
          exp_q.push_back({4'(m_cls), 8'(m_cls + 1)});
        end
      end
    end
  end

  function automatic bit model_led();
    return !(m_busy && m_ticks >= GAP && ((m_ticks - GAP) % 2 == 0));
  endfunction

  // ---------------- monitor ----------------
  bit prev_busy = 1'b0;
  bit prev_led = 1'b1;
  int blinks = 0;
  logic [W-1:0] e;

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("health_led", 32'(bus.health_led), 32'(model_led()));
      check("seq_busy", 32'(bus.seq_busy), 32'(m_busy));
      check("seq_done", 32'(bus.seq_done), 32'(m_done));
      check("active_class", 32'(bus.active_class), 32'(m_cls));
      check("class_latched", 32'(bus.class_latched), 32'(m_latched));
      if (bus.seq_busy && !prev_busy) blinks = 0;
      if (prev_led && !bus.health_led) blinks++;
      if (bus.seq_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got seq_done=1 expected no burst pending at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("burst_class", 32'(bus.active_class), 32'(e[11:8]));
          check("burst_blinks", 32'(blinks), 32'(e[7:0]));
        end
      end
      prev_busy = bus.seq_busy;
      prev_led  = bus.health_led;
    end
  end

  // ---------------- driver tasks ----------------
  int tick_per = 4;
  int tick_pct = 50;
  int tick_phase = 0;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      if (tick_per > 0) begin
        bus.blink_tick = (tick_phase == 0);
        tick_phase = (tick_phase + 1) % tick_per;
      end else begin
        bus.blink_tick = ($urandom_range(0, 99) < tick_pct);
      end
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
  endtask

  task automatic pulse_vld(input logic [N-1:0] mask);
    bus.fault_vld = mask;
    step(1);
    bus.fault_vld = '0;
  endtask

  task automatic pulse_clr();
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit hit;
    bus.blink_tick = 1'b0;
    bus.fault_vld  = '0;
    bus.fault_clr  = 1'b0;
    bus.blink_en   = 1'b0;

    // reset with every request asserted: latches must still come up clear
    reset_n = 1'b0;
    bus.fault_vld = '1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk_en = 1'b1;
    step(2);
    bus.fault_vld = '0;
    reset_n = 1'b1;
    step(1);

    // single class 2, tick every 4 cycles, served repeatedly
    bus.blink_en = 1'b1;
    tick_per = 4;
    pulse_vld(N'(1 << 2));
    step(110);

    // round-robin between classes 1 and 4
    pulse_clr();
    pulse_vld(N'((1 << 1) | (1 << 4)));
    step(200);

    // abort during the third lit phase of class 4
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      if (m_busy && m_cls == 4 && m_ticks == GAP + 4) hit = 1'b1;
      else step(1);
    end
    check("abort_reached", 32'(hit), 32'd1);
    pulse_clr();
    step(5);

    // clear and set in the same cycle: the set survives, class 3 shows 4 blinks
    bus.fault_clr = 1'b1;
    bus.fault_vld = N'(1 << 3);
    step(1);
    bus.fault_clr = 1'b0;
    bus.fault_vld = '0;
    step(90);

    // class 10 only with back-to-back ticks: 11 blinks
    pulse_clr();
    pulse_vld(N'(1 << 10));
    tick_per = 1;
    step(80);

    // sequencing disabled: LED held off while latching continues
    bus.blink_en = 1'b0;
    pulse_vld(N'(1 << 5));
    step(40);
    bus.blink_en = 1'b1;
    tick_per = 3;
    step(150);

    // randomized traffic with an occasional mid-burst reset
    tick_per = 0;
    for (int k = 0; k < 6000; k++) begin
      tick_pct = (k < 3000) ? 50 : 100;
      bus.fault_vld = ($urandom_range(0, 99) < 3) ? N'($urandom) : '0;
      bus.fault_clr = ($urandom_range(0, 999) < 4);
      bus.blink_en  = ($urandom_range(0, 999) >= 5);
      reset_n       = (k != 2500);
      step(1);
    end
    bus.fault_vld = '0;
    bus.fault_clr = 1'b0;
    bus.blink_en  = 1'b0;
    reset_n       = 1'b1;
    step(5);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
